// File: rtl/axis_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_gen
// Summary  : AXI-Stream packet source emitting cfg_count packets of cfg_len
//            bytes with a deterministic payload. Define AXIS_PKT_GEN_LFSR_EN
//            to replace the incrementing-byte payload with a 32-bit LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module axis_pkt_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LEN_WIDTH-1:0]    cfg_len,
  input  logic [CNT_WIDTH-1:0]    cfg_count,
  input  logic [GAP_WIDTH-1:0]    cfg_gap,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    pkt_sent,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast
);

  localparam int                   c_BYTES     = DATA_WIDTH / 8;
  localparam logic [LEN_WIDTH-1:0] c_BYTES_LEN = LEN_WIDTH'(c_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [c_BYTES-1:0]    keep;
    logic                  last;
  } beat_t;

`ifdef AXIS_PKT_GEN_LFSR_EN
  localparam logic [31:0] c_PAT_SEED = 32'hFFFF_FFFF;

  // Fibonacci LFSR x^32+x^22+x^2+x+1, shifting toward the MSB.
  function automatic logic [31:0] pat_step(input logic [31:0] p);
    return {p[30:0], p[31] ^ p[21] ^ p[1] ^ p[0]};
  endfunction

  function automatic logic [7:0] pat_lane(input logic [31:0] p, input int i);
    return p[8*(i%4) +: 8];
  endfunction
`else
  localparam logic [31:0] c_PAT_SEED = 32'h0000_0000;
  localparam logic [31:0] c_STEP     = 32'(c_BYTES);

  // Pattern register is the running byte counter of the run.
  function automatic logic [31:0] pat_step(input logic [31:0] p);
    return p + c_STEP;
  endfunction

  function automatic logic [7:0] pat_lane(input logic [31:0] p, input int i);
    return 8'(p + 32'(i));
  endfunction
`endif

  // rem is the byte count still owed in this packet, including this beat.
  function automatic beat_t make_beat(input logic [31:0] pat, input logic [LEN_WIDTH-1:0] rem);
    beat_t b;
    b = '0;
    for (int i = 0; i < c_BYTES; i++) begin
      b.keep[i] = (rem > LEN_WIDTH'(i));
      if (b.keep[i]) b.data[8*i +: 8] = pat_lane(pat, i);
    end
    b.last = (rem <= c_BYTES_LEN);
    return b;
  endfunction

  state_t                r_state,    w_state;
  logic [LEN_WIDTH-1:0]  r_len,      w_len;
  logic [CNT_WIDTH-1:0]  r_count,    w_count;
  logic [GAP_WIDTH-1:0]  r_gap,      w_gap;
  logic [GAP_WIDTH-1:0]  r_gap_cnt,  w_gap_cnt;
  logic [LEN_WIDTH-1:0]  r_rem,      w_rem;
  logic [31:0]           r_pat,      w_pat;
  logic [CNT_WIDTH-1:0]  r_pkt_sent, w_pkt_sent;
  logic                  r_busy,     w_busy;
  logic                  r_done,     w_done;
  logic                  r_tvalid,   w_tvalid;
  logic [DATA_WIDTH-1:0] r_tdata,    w_tdata;
  logic [c_BYTES-1:0]    r_tkeep,    w_tkeep;
  logic                  r_tlast,    w_tlast;

  beat_t       w_beat;
  logic        w_load;
  logic        w_clear;
  logic        w_hs;
  logic        w_last_pkt;
  logic [31:0] w_pat_adv;

  assign w_hs       = r_tvalid & m_tready;
  assign w_pat_adv  = pat_step(r_pat);
  assign w_last_pkt = (r_count != '0) && ((r_pkt_sent + CNT_WIDTH'(1)) == r_count);

  always_comb begin
    w_state    = r_state;
    w_len      = r_len;
    w_count    = r_count;
    w_gap      = r_gap;
    w_gap_cnt  = r_gap_cnt;
    w_rem      = r_rem;
    w_pat      = r_pat;
    w_pkt_sent = r_pkt_sent;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_tvalid   = r_tvalid;
    w_tdata    = r_tdata;
    w_tkeep    = r_tkeep;
    w_tlast    = r_tlast;
    w_beat     = '0;
    w_load     = 1'b0;
    w_clear    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && (cfg_len != '0)) begin
          w_len      = cfg_len;
          w_count    = cfg_count;
          w_gap      = cfg_gap;
          w_pkt_sent = '0;
          w_pat      = c_PAT_SEED;
          w_rem      = cfg_len;
          w_beat     = make_beat(c_PAT_SEED, cfg_len);
          w_load     = 1'b1;
          w_busy     = 1'b1;
          w_state    = S_SEND;
        end
      end
      S_SEND: begin
        if (w_hs) begin
          w_pat = w_pat_adv;
          if (!r_tlast) begin
            w_rem  = r_rem - c_BYTES_LEN;
            w_beat = make_beat(w_pat_adv, r_rem - c_BYTES_LEN);
            w_load = 1'b1;
          end else begin
            if (r_pkt_sent != '1) w_pkt_sent = r_pkt_sent + CNT_WIDTH'(1);
            if (w_last_pkt || abort) begin
              w_clear = 1'b1;
              w_busy  = 1'b0;
              w_done  = 1'b1;
              w_state = S_DONE;
            end else if (r_gap != '0) begin
              w_clear   = 1'b1;
              w_gap_cnt = r_gap;
              w_state   = S_GAP;
            end else begin
              w_rem  = r_len;
              w_beat = make_beat(w_pat_adv, r_len);
              w_load = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_DONE;
        end else if (r_gap_cnt == GAP_WIDTH'(1)) begin
          // r_pat already stepped on the tlast handshake.
          w_rem   = r_len;
          w_beat  = make_beat(r_pat, r_len);
          w_load  = 1'b1;
          w_state = S_SEND;
        end else begin
          w_gap_cnt = r_gap_cnt - GAP_WIDTH'(1);
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    if (w_load) begin
      w_tvalid = 1'b1;
      w_tdata  = w_beat.data;
      w_tkeep  = w_beat.keep;
      w_tlast  = w_beat.last;
    end else if (w_clear) begin
      w_tvalid = 1'b0;
      w_tdata  = '0;
      w_tkeep  = '0;
      w_tlast  = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_count    <= '0;
      r_gap      <= '0;
      r_gap_cnt  <= '0;
      r_rem      <= '0;
      r_pat      <= '0;
      r_pkt_sent <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_tkeep    <= '0;
      r_tlast    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_len      <= w_len;
      r_count    <= w_count;
      r_gap      <= w_gap;
      r_gap_cnt  <= w_gap_cnt;
      r_rem      <= w_rem;
      r_pat      <= w_pat;
      r_pkt_sent <= w_pkt_sent;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_tvalid   <= w_tvalid;
      r_tdata    <= w_tdata;
      r_tkeep    <= w_tkeep;
      r_tlast    <= w_tlast;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign pkt_sent = r_pkt_sent;
  assign m_tvalid = r_tvalid;
  assign m_tdata  = r_tdata;
  assign m_tkeep  = r_tkeep;
  assign m_tlast  = r_tlast;

endmodule

`default_nettype wire
